jtag_tap_master_sequencer: RTL and testbench

//  Tester/host-side initiator for the IEEE 1838 die TAP: drives TCK/TMS/TDI/TRST_N, samples TDO.

---
 rtl/jtag_tap_master_sequencer_pkg.sv | 34 +++
 rtl/jtag_tap_master_sequencer_if.sv | 26 ++
 rtl/jtag_tap_master_sequencer_tck_gen.sv | 38 +++
 rtl/jtag_tap_master_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_jtag_tap_master_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_tap_master_sequencer_pkg.sv
// Shared opcodes, FSM states and fixed TMS navigation patterns for the JTAG TAP master sequencer.
package jtag_master_pkg;

  localparam logic [1:0] OP_TLR      = 2'b00;
  localparam logic [1:0] OP_SHIFT_IR = 2'b01;
  localparam logic [1:0] OP_SHIFT_DR = 2'b10;
  localparam logic [1:0] OP_RUNTEST  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AUTO_TLR,
    ST_TLR,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RTI,
    ST_RESP
  } state_e;

  localparam int unsigned TLR_SLOTS = 6;

  // TMS patterns are stored LSB first: bit k is driven in slot k.
  localparam logic [3:0]  PRE_DR_TMS = 4'b0001;
  localparam int unsigned PRE_DR_LEN = 3;
  localparam logic [3:0]  PRE_IR_TMS = 4'b0011;
  localparam int unsigned PRE_IR_LEN = 4;
  localparam logic [1:0]  POST_TMS   = 2'b01;
  localparam int unsigned POST_LEN   = 2;

  function automatic logic pre_tms(input logic is_ir, input logic [1:0] idx);
    return is_ir ? PRE_IR_TMS[idx] : PRE_DR_TMS[idx];
  endfunction

endpackage

// File: rtl/jtag_tap_master_sequencer_if.sv
// Command/response handshake bundle between host logic and the JTAG TAP master sequencer.
interface jtag_tap_master_sequencer_if #(
  parameter int unsigned MAX_LEN = 128,
  parameter int unsigned LEN_W   = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/jtag_tap_master_sequencer_tck_gen.sv
// TCK divider: toggles TCK every CLK_DIV clk while run_i is high, parks it low otherwise.
module jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             tck_q;
  logic             wrap;

  assign wrap   = (cnt_q == CNT_W'(CLK_DIV - 1));
  // Strobes mark the clk edge on which TCK changes, not the cycle after.
  assign rise_o = run_i && wrap && !tck_q;
  assign fall_o = run_i && wrap && tck_q;
  assign tck_o  = tck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (!run_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/jtag_tap_master_sequencer.sv
// Host-side JTAG TAP master: runs TLR / IR shift / DR shift / run-test commands and returns TDO.
module jtag_tap_master_sequencer
  import jtag_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 128,
  parameter int unsigned LEN_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  jtag_tap_master_sequencer_if.slave bus,
  output logic TCK,
  output logic TMS,
  output logic TDI,
  output logic TRST_N,
  input  logic TDO
);
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  typedef logic [LEN_W:0] slot_t;

  state_e             state_q, state_d;
  slot_t              slot_q, slot_d, slot_inc, slot_last;
  logic [1:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d;
  logic               tms_q, tms_d, tdi_q, tdi_d;
  logic               err_q, err_d, known_q, known_d, trst_q;
  logic               run, rise_tick, fall_tick, len_bad, is_ir;

  assign run = state_q inside {ST_AUTO_TLR, ST_TLR, ST_PRE, ST_SHIFT, ST_POST, ST_RTI};

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (run),
    .tck_o  (TCK),
    .rise_o (rise_tick),
    .fall_o (fall_tick)
  );

  assign len_bad  = (bus.cmd_len == '0) || (32'(bus.cmd_len) > MAX_LEN);
  assign is_ir    = (op_q == OP_SHIFT_IR);
  assign slot_inc = slot_q + slot_t'(1);

  always_comb begin
    case (state_q)
      ST_AUTO_TLR, ST_TLR: slot_last = slot_t'(TLR_SLOTS - 1);
      ST_PRE:              slot_last = is_ir ? slot_t'(PRE_IR_LEN - 1) : slot_t'(PRE_DR_LEN - 1);
      ST_POST:             slot_last = slot_t'(POST_LEN - 1);
      default:             slot_last = {1'b0, len_q} - slot_t'(1);
    endcase
  end

  // Every fall_tick closes the current slot and loads TMS/TDI for the next one.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    err_d   = err_q;
    known_d = known_q;
    case (state_q)
      ST_IDLE: begin
        if (trst_q && bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          len_d  = bus.cmd_len;
          data_d = bus.cmd_data;
          cap_d  = '0;
          err_d  = 1'b0;
          slot_d = '0;
          case (bus.cmd_op)
            OP_TLR: begin
              state_d = ST_TLR;
              tms_d   = 1'b1;
            end
            OP_SHIFT_IR, OP_SHIFT_DR: begin
              if (len_bad) begin
                state_d = ST_RESP;
                err_d   = 1'b1;
              end else begin
                state_d = known_q ? ST_PRE : ST_AUTO_TLR;
                tms_d   = 1'b1;
              end
            end
            default: begin
              if (bus.cmd_len == '0) begin
                state_d = ST_RESP;
              end else begin
                state_d = ST_RTI;
                tms_d   = 1'b0;
              end
            end
          endcase
        end
      end
      ST_AUTO_TLR, ST_TLR: begin
        if (fall_tick) begin
          if (slot_q == slot_last) begin
            known_d = 1'b1;
            slot_d  = '0;
            if (state_q == ST_AUTO_TLR) begin
              state_d = ST_PRE;
              tms_d   = pre_tms(is_ir, 2'd0);
            end else begin
              state_d = ST_RESP;
            end
          end else begin
            slot_d = slot_inc;
            tms_d  = (slot_inc != slot_t'(TLR_SLOTS - 1));
          end
        end
      end
      ST_PRE: begin
        if (fall_tick) begin
          if (slot_q == slot_last) begin
            state_d = ST_SHIFT;
            slot_d  = '0;
            tms_d   = (len_q == LEN_W'(1));
            tdi_d   = data_q[0];
            data_d  = data_q >> 1;
          end else begin
            slot_d = slot_inc;
            tms_d  = pre_tms(is_ir, slot_inc[1:0]);
          end
        end
      end
      ST_SHIFT: begin
        if (rise_tick) begin
          cap_d[slot_q[IDX_W-1:0]] = TDO;
        end
        if (fall_tick) begin
          if (slot_q == slot_last) begin
            state_d = ST_POST;
            slot_d  = '0;
            tms_d   = POST_TMS[0];
            tdi_d   = 1'b0;
          end else begin
            slot_d = slot_inc;
            tms_d  = (slot_inc == slot_last);
            tdi_d  = data_q[0];
            data_d = data_q >> 1;
          end
        end
      end
      ST_POST: begin
        if (fall_tick) begin
          if (slot_q == slot_last) begin
            state_d = ST_RESP;
          end else begin
            slot_d = slot_inc;
            tms_d  = POST_TMS[1];
          end
        end
      end
      ST_RTI: begin
        if (fall_tick) begin
          if (slot_q == slot_last) state_d = ST_RESP;
          else                     slot_d  = slot_inc;
        end
      end
      default: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      op_q    <= OP_TLR;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      err_q   <= 1'b0;
      known_q <= 1'b0;
      trst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      op_q    <= op_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      err_q   <= err_d;
      known_q <= known_d;
      trst_q  <= 1'b1;
    end
  end

  assign TMS           = tms_q;
  assign TDI           = tdi_q;
  assign TRST_N        = trst_q;
  assign bus.cmd_ready = trst_q && (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = cap_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = run;
endmodule

// File: tb/tb_jtag_tap_master_sequencer.sv
// Bench: die TAP model on the JTAG pins plus a slot-list reference model of the expected TMS/TDI/TDO.
module tb_jtag_tap_master_sequencer;
  import jtag_master_pkg::*;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned MAX_LEN = 128;
  localparam int unsigned LEN_W   = 8;
  localparam logic [3:0]  IR_IDCODE = 4'h2;
  localparam logic [3:0]  IR_BYPASS = 4'hF;
  localparam logic [31:0] DIE_ID    = 32'h1838_0001;

  localparam int S_TLR = 0, S_RTI = 1, S_SELDR = 2, S_CAPDR = 3, S_SHDR = 4, S_EX1DR = 5,
                 S_PADR = 6, S_EX2DR = 7, S_UPDR = 8, S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11,
                 S_EX1IR = 12, S_PAIR = 13, S_EX2IR = 14, S_UPIR = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic TCK, TMS, TDI, TRST_N, TDO;

  jtag_tap_master_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_tap_master_sequencer #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .TCK    (TCK),
    .TMS    (TMS),
    .TDI    (TDI),
    .TRST_N (TRST_N),
    .TDO    (TDO)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- die: IEEE 1149.1 TAP with BYPASS and IDCODE ----------------
  function automatic int tap_next(input int s, input logic m);
    case (s)
      S_TLR:   return m ? S_TLR   : S_RTI;
      S_RTI:   return m ? S_SELDR : S_RTI;
      S_SELDR: return m ? S_SELIR : S_CAPDR;
      S_CAPDR: return m ? S_EX1DR : S_SHDR;
      S_SHDR:  return m ? S_EX1DR : S_SHDR;
      S_EX1DR: return m ? S_UPDR  : S_PADR;
      S_PADR:  return m ? S_EX2DR : S_PADR;
      S_EX2DR: return m ? S_UPDR  : S_SHDR;
      S_UPDR:  return m ? S_SELDR : S_RTI;
      S_SELIR: return m ? S_TLR   : S_CAPIR;
      S_CAPIR: return m ? S_EX1IR : S_SHIR;
      S_SHIR:  return m ? S_EX1IR : S_SHIR;
      S_EX1IR: return m ? S_UPIR  : S_PAIR;
      S_PAIR:  return m ? S_EX2IR : S_PAIR;
      S_EX2IR: return m ? S_UPIR  : S_SHIR;
      default: return m ? S_SELDR : S_RTI;
    endcase
  endfunction

  int           tap_s   = S_TLR;
  logic [3:0]   die_ir  = IR_BYPASS;
  logic [127:0] die_sr  = '0;
  int unsigned  die_len = 1;
  logic         die_tdo = 1'b0;
  assign TDO = die_tdo;

  always @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tap_s  <= S_TLR;
      die_ir <= IR_BYPASS;
    end else begin
      case (tap_s)
        S_CAPDR: begin
          die_sr  <= (die_ir == IR_IDCODE) ? {96'b0, DIE_ID} : '0;
          die_len <= (die_ir == IR_IDCODE) ? 32 : 1;
        end
        S_CAPIR: begin
          die_sr  <= 128'h1;
          die_len <= 4;
        end
        S_SHDR, S_SHIR: die_sr <= (die_sr >> 1) | (128'(TDI) << (die_len - 1));
        default: ;
      endcase
      tap_s <= tap_next(tap_s, TMS);
      if (tap_next(tap_s, TMS) == S_TLR) die_ir <= IR_BYPASS;
      else if (tap_s == S_UPIR)          die_ir <= die_sr[3:0];
    end
  end

  always @(negedge TCK) die_tdo <= (tap_s == S_SHDR || tap_s == S_SHIR) ? die_sr[0] : 1'b0;

  // ---------------- pin monitor: TMS/TDI per rising TCK ----------------
  logic        mon_tms [1024];
  logic        mon_tdi [1024];
  int unsigned mon_n = 0;
  always @(posedge TCK) begin
    mon_tms[mon_n % 1024] <= TMS;
    mon_tdi[mon_n % 1024] <= TDI;
    mon_n <= mon_n + 1;
  end

  // ---------------- reference model: expected slot list ----------------
  bit           m_known = 1'b0;
  logic [3:0]   m_ir    = IR_BYPASS;
  logic [255:0] e_tms, e_tdi;
  int unsigned  e_n;

  task automatic push(input logic t, input logic d);
    e_tms[e_n] = t;
    e_tdi[e_n] = d;
    e_n++;
  endtask

  task automatic push_tlr();
    for (int unsigned i = 0; i < 5; i++) push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    m_known = 1'b1;
    m_ir    = IR_BYPASS;
  endtask

  task automatic offer(input logic [1:0] op, input int unsigned len, input logic [127:0] data,
                       output bit ok, output int unsigned acc, output int unsigned s0);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = data;
    for (int unsigned k = 0; k < 100 && !bus.cmd_ready; k++) @(negedge clk);
    ok  = bus.cmd_ready;
    acc = cyc + 1;
    s0  = mon_n;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int unsigned idx, input logic [1:0] op, input int unsigned len,
                         input logic [127:0] data, input int unsigned hold, output logic [127:0] obs);
    logic [255:0] e_rsp, comb, o_tms, o_tdi;
    logic [127:0] cval;
    logic         e_err;
    int unsigned  L, s0, acc, lat, lo, got_n, k;
    bit           ok;
    e_n = 0; e_tms = '0; e_tdi = '0; e_rsp = '0; e_err = 1'b0; L = 1; cval = '0; obs = '0;
    if (op == OP_TLR) begin
      push_tlr();
    end else if (op == OP_RUNTEST) begin
      for (int unsigned i = 0; i < len; i++) push(1'b0, 1'b0);
    end else if (len == 0 || len > MAX_LEN) begin
      e_err = 1'b1;
    end else begin
      if (!m_known) push_tlr();
      if (op == OP_SHIFT_IR) begin
        push(1, 0); push(1, 0); push(0, 0); push(0, 0);
        L = 4; cval = 128'h1;
      end else begin
        push(1, 0); push(0, 0); push(0, 0);
        if (m_ir == IR_IDCODE) begin L = 32; cval = {96'b0, DIE_ID}; end
      end
      for (int unsigned i = 0; i < len; i++) push(i == len - 1, data[i]);
      push(1, 0); push(0, 0);
      comb  = ({128'b0, data} << L) | {128'b0, cval};
      e_rsp = comb & ((256'b1 << len) - 256'b1);
      if (op == OP_SHIFT_IR) m_ir = comb[len +: 4];
    end

    offer(op, len, data, ok, acc, s0);
    chk($sformatf("c%0d accept", idx), ok, 1'b1);
    if (!ok) return;
    chk($sformatf("c%0d busy", idx), bus.busy, e_n > 0);
    k = 0;
    while (!bus.rsp_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("c%0d rsp_valid", idx), bus.rsp_valid, 1'b1);
    if (!bus.rsp_valid) return;
    lat = cyc - acc;
    lo  = 2 * CLK_DIV * e_n;
    chk($sformatf("c%0d latency %0d in [%0d,%0d]", idx, lat, lo, lo + 2),
        (lat >= lo) && (lat <= lo + 2), 1'b1);
    chk($sformatf("c%0d rsp_err", idx), bus.rsp_err, e_err);
    chk($sformatf("c%0d rsp_data", idx), bus.rsp_data, e_rsp);
    obs   = bus.rsp_data;
    got_n = mon_n - s0;
    chk($sformatf("c%0d tck_count", idx), got_n, e_n);
    o_tms = '0; o_tdi = '0;
    for (int unsigned i = 0; i < got_n && i < 256; i++) begin
      o_tms[i] = mon_tms[(s0 + i) % 1024];
      o_tdi[i] = mon_tdi[(s0 + i) % 1024];
    end
    chk($sformatf("c%0d tms_seq", idx), o_tms, e_tms);
    chk($sformatf("c%0d tdi_seq", idx), o_tdi, e_tdi);
    if (e_n > 0) chk($sformatf("c%0d die_in_rti", idx), tap_s, S_RTI);
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("c%0d hold vld/rdy/tck/busy", idx),
          {bus.rsp_valid, bus.cmd_ready, TCK, bus.busy}, 4'b1000);
      chk($sformatf("c%0d hold data", idx), {bus.rsp_err, bus.rsp_data}, {e_err, e_rsp[127:0]});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk($sformatf("c%0d after handshake vld/rdy", idx), {bus.rsp_valid, bus.cmd_ready}, 2'b01);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " pins"}, {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.busy, TCK, TMS, TDI, TRST_N},
        8'b0000_0100);
    chk({tag, " rsp_data"}, bus.rsp_data, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    m_known = 1'b0;
    m_ir    = IR_BYPASS;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("reset release trst/ready", {TRST_N, bus.cmd_ready}, 2'b11);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] obs, rd;
    logic [1:0]   op;
    int unsigned  len, r, acc, s0;
    bit           ok;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_TLR;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    do_reset();
    run_cmd(1, OP_TLR, 0, '0, 0, obs);

    do_reset();
    run_cmd(2, OP_SHIFT_DR, 8, 128'h5A, 0, obs);
    chk("bypass 5A result", obs, 128'hB4);

    run_cmd(3, OP_SHIFT_IR, 4, {124'b0, IR_IDCODE}, 0, obs);
    run_cmd(4, OP_SHIFT_DR, 32, '0, 0, obs);
    chk("idcode result", obs, {96'b0, DIE_ID});

    run_cmd(5, OP_SHIFT_DR, 0, 128'hFF, 0, obs);
    run_cmd(6, OP_SHIFT_DR, 129, 128'hFF, 0, obs);
    run_cmd(7, OP_SHIFT_IR, 0, 128'h3, 0, obs);

    run_cmd(8, OP_SHIFT_DR, 16, 128'hC3A5, 10, obs);
    run_cmd(9, OP_RUNTEST, 0, '0, 10, obs);
    run_cmd(10, OP_RUNTEST, 7, '1, 2, obs);

    for (int unsigned c = 0; c < 40; c++) begin
      op = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      rd = {$urandom, $urandom, $urandom, $urandom};
      case (op)
        OP_SHIFT_DR: len = (r == 0) ? 0 : (r == 1) ? $urandom_range(129, 255) : $urandom_range(1, 128);
        OP_SHIFT_IR: begin
          len = (r < 6) ? 4 : (r == 6) ? 0 : $urandom_range(1, 12);
          if (len == 4 && $urandom_range(0, 1) == 1) rd[3:0] = IR_IDCODE;
        end
        OP_RUNTEST:  len = $urandom_range(0, 20);
        default:     len = $urandom_range(0, 255);
      endcase
      run_cmd(100 + c, op, len, rd, $urandom_range(0, 3), obs);
    end

    // Reset pulsed in the middle of a 128-bit shift.
    rd = {$urandom, $urandom, $urandom, $urandom};
    r  = m_known ? 3 : 9;
    offer(OP_SHIFT_DR, 128, rd, ok, acc, s0);
    chk("midreset accept", ok, 1'b1);
    for (int unsigned k = 0; k < 5000 && (mon_n - s0) < r + 40; k++) @(negedge clk);
    chk("midreset reached bit 40", (mon_n - s0) >= r + 40, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    m_known = 1'b0;
    m_ir    = IR_BYPASS;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("midreset release trst/ready", {TRST_N, bus.cmd_ready}, 2'b11);
    run_cmd(200, OP_SHIFT_DR, 8, 128'h5A, 0, obs);
    chk("post-reset bypass result", obs, 128'hB4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
